pipe_ctrl: RTL and testbench

//  Parametrised pipeline sequencer for the core: owns the run-mode FSM (IDLE/LOAD/EXEC/HALT),

---
 rtl/pipe_ctrl.sv | 140 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: run-mode FSM, execute latency counter, per-stage update codes, perf counters.
// upd/ex_done are combinational from state+inputs; everything else is registered (1 cycle); ex_busy stalls completion.
module pipe_ctrl #(
   parameter int NSTAGE = 3,
   parameter int LAT_W  = 5,
   parameter int CNT_W  = 32
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  boot_req,
   input  logic                  load_done,
   input  logic                  boot_ack,
   input  logic                  stop_req,
   input  logic                  resume,
   input  logic [LAT_W-1:0]      exec_wait,
   input  logic                  ex_busy,
   input  logic                  hazard,
   input  logic                  redirect,
   output logic [2*NSTAGE-1:0]   upd,
   output logic [1:0]            mode,
   output logic                  ex_done,
   output logic                  ex_start,
   output logic [CNT_W-1:0]      cyc_cnt,
   output logic [CNT_W-1:0]      stall_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_EXEC = 2'd2,
      ST_HALT = 2'd3
   } mode_e;

   localparam logic [1:0] UPD_HOLD  = 2'b00;
   localparam logic [1:0] UPD_ADV   = 2'b01;
   localparam logic [1:0] UPD_FLUSH = 2'b10;

   mode_e            mode_q, mode_d;
   logic [LAT_W-1:0] lat_q, lat_d;
   logic             stop_mask_q, stop_mask_d;
   logic             ex_start_q, ex_start_d;
   logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             halt_now;

   assign ex_done  = (mode_q == ST_EXEC) && (lat_q == exec_wait) && !ex_busy;
   // A stop retiring for the second time (after resume) is masked so it advances instead of re-halting.
   assign halt_now = ex_done && stop_req && !stop_mask_q;

   always_comb begin
      upd = '0;
      for (int i = 0; i < NSTAGE; i++) begin
         case (mode_q)
            ST_IDLE, ST_LOAD: upd[2*i +: 2] = UPD_FLUSH;
            ST_HALT:          upd[2*i +: 2] = UPD_HOLD;
            default: begin
               if (!ex_done || halt_now) begin
                  upd[2*i +: 2] = UPD_HOLD;
               end else if (i == 0) begin
                  upd[2*i +: 2] = (redirect || !hazard) ? UPD_ADV : UPD_HOLD;
               end else if (i == 1) begin
                  upd[2*i +: 2] = (hazard || redirect) ? UPD_FLUSH : UPD_ADV;
               end else begin
                  upd[2*i +: 2] = UPD_ADV;
               end
            end
         endcase
      end
   end

   always_comb begin
      mode_d      = mode_q;
      lat_d       = '0;
      stop_mask_d = stop_mask_q;
      ex_start_d  = ex_done;
      cyc_cnt_d   = cyc_cnt_q;
      stall_cnt_d = stall_cnt_q;
      case (mode_q)
         ST_IDLE: begin
            if (boot_req) mode_d = ST_LOAD;
         end
         ST_LOAD: begin
            stop_mask_d = 1'b0;
            if (load_done && boot_ack) mode_d = ST_EXEC;
         end
         ST_EXEC: begin
            if (ex_done) begin
               lat_d = '0;
            end else if (lat_q < exec_wait) begin
               lat_d = lat_q + LAT_W'(1);
            end else begin
               lat_d = lat_q;
            end
            if (halt_now) begin
               mode_d      = ST_HALT;
               stop_mask_d = 1'b1;
            end else if (ex_done) begin
               stop_mask_d = 1'b0;
            end
            if (cyc_cnt_q != '1) cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
            if (upd[1:0] != UPD_ADV && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
         end
         default: begin
            if (boot_req) begin
               mode_d = ST_LOAD;
            end else if (resume) begin
               mode_d = ST_EXEC;
            end
         end
      endcase
      if (mode_d == ST_LOAD && mode_q != ST_LOAD) begin
         cyc_cnt_d   = '0;
         stall_cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         mode_q      <= ST_IDLE;
         lat_q       <= '0;
         stop_mask_q <= 1'b0;
         ex_start_q  <= 1'b0;
         cyc_cnt_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         mode_q      <= mode_d;
         lat_q       <= lat_d;
         stop_mask_q <= stop_mask_d;
         ex_start_q  <= ex_start_d;
         cyc_cnt_q   <= cyc_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign mode      = mode_q;
   assign ex_start  = ex_start_q;
   assign cyc_cnt   = cyc_cnt_q;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed sequences plus random inputs, every cycle compared against a behavioural model.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_pipe_ctrl;
   localparam int     NSTAGE = 4;
   localparam int     LAT_W  = 5;
   localparam int     CNT_W  = 8;
   localparam longint CMAX   = (64'd1 << CNT_W) - 1;

   logic                 clk = 1'b0;
   logic                 rstn, boot_req, load_done, boot_ack, stop_req, resume;
   logic [LAT_W-1:0]     exec_wait;
   logic                 ex_busy, hazard, redirect;
   logic [2*NSTAGE-1:0]  upd;
   logic [1:0]           mode;
   logic                 ex_done, ex_start;
   logic [CNT_W-1:0]     cyc_cnt, stall_cnt;

   pipe_ctrl #(.NSTAGE(NSTAGE), .LAT_W(LAT_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rstn(rstn), .boot_req(boot_req), .load_done(load_done), .boot_ack(boot_ack),
      .stop_req(stop_req), .resume(resume), .exec_wait(exec_wait), .ex_busy(ex_busy),
      .hazard(hazard), .redirect(redirect), .upd(upd), .mode(mode), .ex_done(ex_done),
      .ex_start(ex_start), .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: 0 idle, 1 load, 2 exec, 3 halt
   int     m_mode, m_lat;
   bit     m_mask, m_start;
   longint m_cyc, m_stall;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_lat = 0; m_mask = 0; m_start = 0; m_cyc = 0; m_stall = 0;
   endtask

   // What each pipeline register should do this cycle: 0 hold, 1 advance, 2 flush
   function automatic logic [1:0] want_code(int i, bit exd, bit halt);
      if (m_mode <= 1) return 2'd2;
      if (m_mode == 3 || !exd || halt) return 2'd0;
      if (i == 0) return (hazard && !redirect) ? 2'd0 : 2'd1;
      if (i == 1) return (hazard || redirect) ? 2'd2 : 2'd1;
      return 2'd1;
   endfunction

   // One clock: called at a falling edge with inputs already driven; returns at the next falling edge.
   task automatic step();
      bit                  exd, halt;
      logic [2*NSTAGE-1:0] eupd;
      int                  nmode;
      #1;
      exd  = (m_mode == 2) && (m_lat == int'(exec_wait)) && !ex_busy;
      halt = exd && stop_req && !m_mask;
      eupd = '0;
      for (int i = 0; i < NSTAGE; i++) eupd[2*i +: 2] = want_code(i, exd, halt);
      check_eq("mode", mode, m_mode);
      check_eq("ex_done", ex_done, exd);
      check_eq("upd", upd, eupd);
      check_eq("ex_start", ex_start, m_start);
      check_eq("cyc_cnt", cyc_cnt, m_cyc);
      check_eq("stall_cnt", stall_cnt, m_stall);
      if (!rstn) begin
         model_reset();
      end else begin
         nmode = m_mode;
         case (m_mode)
            0: if (boot_req) nmode = 1;
            1: if (load_done && boot_ack) nmode = 2;
            2: if (halt) nmode = 3;
            default: if (boot_req) nmode = 1; else if (resume) nmode = 2;
         endcase
         if (m_mode == 2) begin
            if (exd) m_lat = 0;
            else if (m_lat < int'(exec_wait)) m_lat = m_lat + 1;
            if (halt) m_mask = 1; else if (exd) m_mask = 0;
            if (m_cyc < CMAX) m_cyc++;
            if (eupd[1:0] != 2'd1 && m_stall < CMAX) m_stall++;
         end else begin
            m_lat = 0;
            if (m_mode == 1) m_mask = 0;
         end
         if (nmode == 1 && m_mode != 1) begin
            m_cyc = 0; m_stall = 0;
         end
         m_start = exd;
         m_mode  = nmode;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic quiet_inputs();
      rstn = 1; boot_req = 0; load_done = 0; boot_ack = 0; stop_req = 0; resume = 0;
      ex_busy = 0; hazard = 0; redirect = 0;
   endtask

   task automatic boot();
      boot_req = 1; step(); boot_req = 0;
      load_done = 1; boot_ack = 1; step(); load_done = 0; boot_ack = 0;
   endtask

   initial begin
      quiet_inputs();
      exec_wait = 5'd3;
      rstn = 0;
      @(posedge clk); @(posedge clk); @(negedge clk);
      model_reset();
      step();
      rstn = 1;
      check_eq("reset_upd_flush", upd, {NSTAGE{2'b10}});

      // Boot handshake; load_done alone must not leave LOAD
      boot_req = 1; step(); boot_req = 0;
      load_done = 1; step(); step();
      check_eq("load_hold", mode, 2'd1);
      boot_ack = 1; step(); load_done = 0; boot_ack = 0;
      check_eq("boot_exec", mode, 2'd2);

      repeat (12) step();
      hazard = 1;   repeat (8) step();
      hazard = 0; redirect = 1; repeat (8) step();
      redirect = 0;

      // Halt on stop, stay halted, resume and retire the stop without re-halting
      stop_req = 1; repeat (4) step();
      check_eq("halted", mode, 2'd3);
      boot_req = 0; repeat (3) step();
      resume = 1; step(); resume = 0;
      repeat (5) step();
      check_eq("no_rehalt", mode, 2'd2);
      repeat (4) step();
      check_eq("second_stop_halts", mode, 2'd3);
      stop_req = 0;
      boot_req = 1; resume = 1; step(); boot_req = 0; resume = 0;
      check_eq("halt_boot_load", mode, 2'd1);
      check_eq("load_cyc_clear", cyc_cnt, 0);

      // Reset in the middle of an execute wait
      load_done = 1; boot_ack = 1; step(); load_done = 0; boot_ack = 0;
      repeat (2) step();
      rstn = 0; step(); rstn = 1;
      check_eq("mid_reset_idle", mode, 2'd0);
      boot();
      repeat (10) step();

      // Saturate both counters: completion every cycle, stage 0 stalled by hazard
      exec_wait = 5'd0; hazard = 1;
      repeat (300) step();
      check_eq("cyc_sat", cyc_cnt, CMAX);
      check_eq("stall_sat", stall_cnt, CMAX);
      hazard = 0;

      for (int n = 0; n < 4000; n++) begin
         rstn      = ($urandom_range(0, 199) != 0);
         boot_req  = ($urandom_range(0, 15) == 0);
         load_done = $urandom_range(0, 1);
         boot_ack  = $urandom_range(0, 1);
         stop_req  = ($urandom_range(0, 5) == 0);
         resume    = ($urandom_range(0, 3) == 0);
         ex_busy   = ($urandom_range(0, 3) == 0);
         hazard    = ($urandom_range(0, 2) == 0);
         redirect  = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 49) == 0) exec_wait = LAT_W'($urandom_range(0, 4));
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
